// File: rtl/dechannelizer_pkg.sv
// Shared types and helpers for the frame dechannelizer.
// Holds the serializer state encoding and the channel-index width rule.
package dechannelizer_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } dch_state_e;

    // A single-channel build still needs a 1-bit channel index port.
    function automatic int chan_idx_w(input int channels);
        return (channels <= 1) ? 1 : $clog2(channels);
    endfunction

endpackage

// File: rtl/dechannelizer_frame_buf.sv
// One-frame-deep holding buffer that sits behind the active frame.
// A simultaneous read and write keeps it full with the newly written frame.
module dechannelizer_frame_buf #(
    parameter int FRAME_W = 48
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               write,
    input  logic               read,
    input  logic [FRAME_W-1:0] wdata,
    output logic               full,
    output logic [FRAME_W-1:0] data
);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            full <= 1'b0;
            data <= '0;
        end else begin
            if (write) begin
                data <= wdata;
            end
            if (write) begin
                full <= 1'b1;
            end else if (read) begin
                full <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/dechannelizer_n.sv
// Serializes a parallel multi-channel frame into one sample per beat with
// sop/eop/channel sideband, a one-frame pending buffer and drop reporting.
//
// state | meaning
// IDLE  | no active frame, outputs invalid, out_data holds last beat
// SEND  | active frame presented one channel per beat, counter = channel
module dechannelizer_n
    import dechannelizer_pkg::*;
#(
    parameter int WIDTH     = 24,
    parameter int CHANNELS  = 2,
    parameter int EDGE_TRIG = 1
) (
    input  logic                            clk,
    input  logic                            reset_n,
    input  logic [CHANNELS*WIDTH-1:0]       in_data,
    input  logic                            in_valid,
    input  logic                            out_ready,
    output logic [WIDTH-1:0]                out_data,
    output logic                            out_valid,
    output logic                            out_sop,
    output logic                            out_eop,
    output logic [chan_idx_w(CHANNELS)-1:0] out_channel,
    output logic                            overflow
);

    localparam int             CW   = chan_idx_w(CHANNELS);
    localparam int             FW   = CHANNELS * WIDTH;
    localparam logic [CW-1:0]  LAST = CW'(CHANNELS - 1);

    dch_state_e     state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [FW-1:0]  active_q, active_d;
    logic           in_valid_q;
    logic           ovf_q, ovf_d;
    logic           trig;
    logic           xfer;
    logic           eop_xfer;
    logic           buf_wr;
    logic           buf_rd;
    logic           buf_full;
    logic [FW-1:0]  buf_data;

    // History resets low so a level already high at release counts as an edge.
    always_comb begin
        trig     = in_valid && ((EDGE_TRIG == 0) || !in_valid_q);
        xfer     = (state_q == SEND) && out_ready;
        eop_xfer = xfer && (cnt_q == LAST);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            active_q   <= '0;
            in_valid_q <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            active_q   <= active_d;
            in_valid_q <= in_valid;
            ovf_q      <= ovf_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        active_d = active_q;
        buf_wr   = 1'b0;
        buf_rd   = 1'b0;
        ovf_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (trig) begin
                    active_d = in_data;
                    cnt_d    = '0;
                    state_d  = SEND;
                end
            end
            SEND: begin
                if (eop_xfer) begin
                    // Frame retires this cycle, so a new trigger always has room.
                    if (buf_full) begin
                        active_d = buf_data;
                        cnt_d    = '0;
                        buf_rd   = 1'b1;
                        buf_wr   = trig;
                    end else if (trig) begin
                        active_d = in_data;
                        cnt_d    = '0;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    if (xfer) begin
                        cnt_d = cnt_q + 1'b1;
                    end
                    if (trig) begin
                        if (buf_full) begin
                            ovf_d = 1'b1;
                        end else begin
                            buf_wr = 1'b1;
                        end
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    dechannelizer_frame_buf #(
        .FRAME_W (FW)
    ) u_pending (
        .clk     (clk),
        .reset_n (reset_n),
        .write   (buf_wr),
        .read    (buf_rd),
        .wdata   (in_data),
        .full    (buf_full),
        .data    (buf_data)
    );

    // Counter and active frame are left untouched in IDLE, which holds out_data.
    assign out_data    = active_q[int'(cnt_q) * WIDTH +: WIDTH];
    assign out_valid   = (state_q == SEND);
    assign out_sop     = out_valid && (cnt_q == '0);
    assign out_eop     = out_valid && (cnt_q == LAST);
    assign out_channel = cnt_q;
    assign overflow    = ovf_q;

endmodule

// File: tb/tb_dechannelizer_n.sv
// Directed bench: three dechannelizer builds (2ch level, 4ch edge, 1ch edge)
// share stimulus and are checked each cycle against a frame-queue model.
module tb_dechannelizer_n;

    localparam int W = 24;

    logic clk = 1'b0;
    logic reset_n;
    logic in_valid  = 1'b0;
    logic out_ready = 1'b0;
    logic [W-1:0] smp [4];

    logic [2*W-1:0] in_d2;
    logic [4*W-1:0] in_d4;
    logic [W-1:0]   in_d1;

    logic [W-1:0] d2, d4, d1;
    logic v2, v4, v1, s2, s4, s1, e2, e4, e1, o2, o4, o1;
    logic       c2, c1;
    logic [1:0] c4;

    logic [W-1:0] od [3];
    logic ov [3];
    logic os [3];
    logic oe [3];
    logic oo [3];
    int   och [3];

    int checks   = 0;
    int failures = 0;

    // Model: list of held frames (head is being serialized) per instance.
    logic [W-1:0] mfr   [3][2][4];
    int           mn    [3];
    int           mbeat [3];
    logic [W-1:0] mlast [3];
    logic         movf  [3];
    logic         mprev;

    int sop_cnt [3];
    int ovf_cnt [3];

    always #5 clk = ~clk;

    assign in_d2 = {smp[1], smp[0]};
    assign in_d4 = {smp[3], smp[2], smp[1], smp[0]};
    assign in_d1 = smp[0];

    dechannelizer_n #(.WIDTH(W), .CHANNELS(2), .EDGE_TRIG(0)) u2 (
        .clk(clk), .reset_n(reset_n), .in_data(in_d2), .in_valid(in_valid),
        .out_ready(out_ready), .out_data(d2), .out_valid(v2), .out_sop(s2),
        .out_eop(e2), .out_channel(c2), .overflow(o2));

    dechannelizer_n #(.WIDTH(W), .CHANNELS(4), .EDGE_TRIG(1)) u4 (
        .clk(clk), .reset_n(reset_n), .in_data(in_d4), .in_valid(in_valid),
        .out_ready(out_ready), .out_data(d4), .out_valid(v4), .out_sop(s4),
        .out_eop(e4), .out_channel(c4), .overflow(o4));

    dechannelizer_n #(.WIDTH(W), .CHANNELS(1), .EDGE_TRIG(1)) u1 (
        .clk(clk), .reset_n(reset_n), .in_data(in_d1), .in_valid(in_valid),
        .out_ready(out_ready), .out_data(d1), .out_valid(v1), .out_sop(s1),
        .out_eop(e1), .out_channel(c1), .overflow(o1));

    always_comb begin
        od[0] = d2; ov[0] = v2; os[0] = s2; oe[0] = e2; oo[0] = o2; och[0] = int'(c2);
        od[1] = d4; ov[1] = v4; os[1] = s4; oe[1] = e4; oo[1] = o4; och[1] = int'(c4);
        od[2] = d1; ov[2] = v1; os[2] = s1; oe[2] = e1; oo[2] = o1; och[2] = int'(c1);
    end

    function automatic int chans(input int k);
        case (k)
            0:       return 2;
            1:       return 4;
            default: return 1;
        endcase
    endfunction

    function automatic bit level_trig(input int k);
        return (k == 0);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        for (int k = 0; k < 3; k++) begin
            mn[k]    = 0;
            mbeat[k] = 0;
            mlast[k] = '0;
            movf[k]  = 1'b0;
        end
        mprev = 1'b0;
    endtask

    // Advance the model across the coming rising edge using the present inputs.
    task automatic model_update();
        bit trig;
        if (!reset_n) begin
            model_clear();
            return;
        end
        for (int k = 0; k < 3; k++) begin
            if (ov[k] && os[k] && out_ready) sop_cnt[k]++;
            trig    = in_valid && (level_trig(k) || !mprev);
            movf[k] = 1'b0;
            if (mn[k] > 0 && out_ready) begin
                if (mbeat[k] == chans(k) - 1) begin
                    for (int j = 0; j < 4; j++) mfr[k][0][j] = mfr[k][1][j];
                    mn[k]--;
                    mbeat[k] = 0;
                end else begin
                    mbeat[k]++;
                end
            end
            if (trig) begin
                if (mn[k] < 2) begin
                    for (int j = 0; j < 4; j++) mfr[k][mn[k]][j] = smp[j];
                    mn[k]++;
                end else begin
                    movf[k] = 1'b1;
                end
            end
            if (mn[k] > 0) mlast[k] = mfr[k][0][mbeat[k]];
        end
        mprev = in_valid;
    endtask

    task automatic compare_all();
        bit v;
        for (int k = 0; k < 3; k++) begin
            v = (mn[k] > 0);
            chk($sformatf("u%0d_valid", k), 32'(ov[k]), 32'(v));
            chk($sformatf("u%0d_data", k), 32'(od[k]), v ? 32'(mfr[k][0][mbeat[k]]) : 32'(mlast[k]));
            chk($sformatf("u%0d_sop", k), 32'(os[k]), 32'(v && mbeat[k] == 0));
            chk($sformatf("u%0d_eop", k), 32'(oe[k]), 32'(v && mbeat[k] == chans(k) - 1));
            if (v || !reset_n) chk($sformatf("u%0d_channel", k), 32'(och[k]), v ? 32'(mbeat[k]) : 32'd0);
            chk($sformatf("u%0d_overflow", k), 32'(oo[k]), 32'(movf[k]));
            if (oo[k]) ovf_cnt[k]++;
        end
    endtask

    task automatic step();
        model_update();
        @(posedge clk);
        #2;
        compare_all();
    endtask

    task automatic set_frame(input logic [W-1:0] base);
        for (int j = 0; j < 4; j++) smp[j] = base + W'(j);
    endtask

    int o_snap;
    int s_snap [3];
    int v_snap [3];

    initial begin
        for (int k = 0; k < 3; k++) begin
            sop_cnt[k] = 0;
            ovf_cnt[k] = 0;
        end
        for (int j = 0; j < 4; j++) smp[j] = '0;
        model_clear();
        reset_n = 1'b1;
        #1 reset_n = 1'b0;
        #1;
        compare_all();
        chk("reset_u4_valid", 32'(v4), 32'd0);
        chk("reset_u4_data", 32'(d4), 32'd0);
        chk("reset_u4_overflow", 32'(o4), 32'd0);
        out_ready = 1'b1;
        step(); step();
        reset_n = 1'b1;
        step(); step();

        // Single frame on all builds; 2ch pins the basic two-beat sequence.
        smp[0] = 24'h123456; smp[1] = 24'hABCDEF; smp[2] = 24'h111111; smp[3] = 24'h222222;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        chk("two_ch_beat0_data", 32'(d2), 32'h123456);
        chk("two_ch_beat0_sop", 32'(s2), 32'd1);
        chk("two_ch_beat0_chan", 32'(c2), 32'd0);
        chk("one_ch_data", 32'(d1), 32'h123456);
        chk("one_ch_sop_eop", {30'd0, s1, e1}, 32'd3);
        chk("one_ch_chan", 32'(c1), 32'd0);
        step();
        chk("two_ch_beat1_data", 32'(d2), 32'hABCDEF);
        chk("two_ch_beat1_eop", 32'(e2), 32'd1);
        chk("two_ch_beat1_chan", 32'(c2), 32'd1);
        chk("one_ch_done", 32'(v1), 32'd0);
        step();
        chk("two_ch_done", 32'(v2), 32'd0);
        chk("two_ch_hold_data", 32'(d2), 32'hABCDEF);
        step(); step(); step();

        // Backpressure toggling on a 4ch frame; sign bits must pass untouched.
        smp[0] = 24'h800001; smp[1] = 24'h7FFFFF; smp[2] = 24'h000000; smp[3] = 24'hFFFFFF;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        for (int i = 0; i < 10; i++) begin
            out_ready = (i % 2 == 1);
            step();
            if (i == 0) chk("stall_hold_data", 32'(d4), 32'h800001);
            if (i == 1) chk("after_xfer_data", 32'(d4), 32'h7FFFFF);
            if (i == 2) chk("stall_hold_chan", 32'(c4), 32'd1);
        end
        out_ready = 1'b1;
        step(); step(); step();

        // Active + pending filled under stall, third frame dropped.
        out_ready = 1'b0;
        o_snap = ovf_cnt[1];
        set_frame(24'h100000); in_valid = 1'b1; step(); in_valid = 1'b0; step();
        set_frame(24'h200000); in_valid = 1'b1; step(); in_valid = 1'b0; step();
        set_frame(24'h300000); in_valid = 1'b1; step(); in_valid = 1'b0; step(); step();
        chk("drop_ovf_pulses", 32'(ovf_cnt[1] - o_snap), 32'd1);
        chk("drop_head_data", 32'(d4), 32'h100000);
        out_ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            step();
            if (i < 8) begin
                chk($sformatf("burst_valid_%0d", i), 32'(v4), 32'd1);
                chk($sformatf("burst_data_%0d", i), 32'(d4),
                    (i < 4) ? 32'h100000 + 32'(i) : 32'h200000 + 32'(i - 4));
            end else begin
                chk("burst_end_valid", 32'(v4), 32'd0);
            end
        end
        step(); step();

        // in_valid held high for ten cycles.
        for (int k = 0; k < 3; k++) begin
            s_snap[k] = sop_cnt[k];
            v_snap[k] = ovf_cnt[k];
        end
        set_frame(24'h400000);
        in_valid = 1'b1;
        for (int i = 0; i < 10; i++) step();
        in_valid = 1'b0;
        for (int i = 0; i < 16; i++) step();
        chk("level_hold_edge4_frames", 32'(sop_cnt[1] - s_snap[1]), 32'd1);
        chk("level_hold_edge1_frames", 32'(sop_cnt[2] - s_snap[2]), 32'd1);
        chk("level_hold_level2_frames", 32'(sop_cnt[0] - s_snap[0]), 32'd6);
        chk("level_hold_level2_ovf", 32'(ovf_cnt[0] - v_snap[0]), 32'd4);
        $display("level trigger 2ch: overflow pulses=%0d frames=%0d",
                 ovf_cnt[0] - v_snap[0], sop_cnt[0] - s_snap[0]);

        // Reset during beat 2 of a 4ch frame.
        set_frame(24'h500000);
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step(); step();
        chk("pre_reset_chan", 32'(c4), 32'd2);
        #1 reset_n = 1'b0;
        model_clear();
        #1;
        compare_all();
        chk("reset_mid_valid", 32'(v4), 32'd0);
        chk("reset_mid_data", 32'(d4), 32'd0);
        chk("reset_mid_flags", {29'd0, s4, e4, o4}, 32'd0);
        chk("reset_mid_chan", 32'(c4), 32'd0);
        step(); step();
        reset_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            chk($sformatf("post_reset_idle_%0d", i), 32'(v4), 32'd0);
        end

        // in_valid already high when reset releases is a rising edge.
        set_frame(24'h600000);
        in_valid = 1'b1;
        #1 reset_n = 1'b0;
        model_clear();
        step(); step();
        reset_n = 1'b1;
        step();
        chk("release_edge_valid", 32'(v4), 32'd1);
        chk("release_edge_data", 32'(d4), 32'h600000);
        chk("release_edge_sop", 32'(s4), 32'd1);
        in_valid = 1'b0;
        for (int i = 0; i < 6; i++) step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dechannelizer_n.md
DECHANNELIZER_N -- requirements
Module: dechannelizer_n

Interface
REQ-001 Parameter WIDTH, default 24, sample width in bits per channel.
REQ-002 Parameter CHANNELS, default 2, channels per frame; legal range 1..16.
REQ-003 Parameter EDGE_TRIG, default 1; 1 = capture only on in_valid rising edge, 0 = capture on every cycle in_valid is high.
REQ-004 clk  in  1  single clock; all logic on rising edge.
REQ-005 reset_n  in  1  reset, asynchronous assert, active-low.
REQ-006 in_data  in  CHANNELS*WIDTH  parallel frame; channel k at bits [k*WIDTH +: WIDTH].
REQ-007 in_valid  in  1  frame qualifier.
REQ-008 out_ready  in  1  downstream ready; readyLatency 0.
REQ-009 out_data  out  WIDTH  serialized sample.
REQ-010 out_valid  out  1  beat valid.
REQ-011 out_sop  out  1  first beat of frame (channel 0).
REQ-012 out_eop  out  1  last beat of frame (channel CHANNELS-1).
REQ-013 out_channel  out  max(1,clog2(CHANNELS))  channel index of current beat.
REQ-014 overflow  out  1  one-cycle pulse per dropped frame.

Function
REQ-015 Frame trigger: in_valid high in a cycle (EDGE_TRIG=0) or in_valid high while previous-cycle in_valid low (EDGE_TRIG=1).
REQ-016 Two storage stages: active frame (being serialized) and pending frame buffer (one frame deep, with full flag).
REQ-017 States: IDLE (no active frame) and SEND (active frame, beat counter 0..CHANNELS-1).
REQ-018 IDLE + trigger: in_data loads directly into active, counter=0, SEND next cycle; out_valid high one cycle after trigger.
REQ-019 SEND: out_data = active channel[counter], out_channel = counter, out_valid=1, out_sop=(counter==0), out_eop=(counter==CHANNELS-1).
REQ-020 Beat transfers when out_valid && out_ready; counter increments; out_data/out_channel/flags remain stable while out_ready low.
REQ-021 CHANNELS=1: single beat with out_sop and out_eop both high.
REQ-022 Trigger in SEND with pending empty: frame written to pending, no overflow.
REQ-023 EOP transfer with pending full: pending moves to active, counter=0, next cycle presents sop beat (no bubble); pending becomes empty.
REQ-024 EOP transfer with pending empty: return to IDLE; out_valid low next cycle unless a trigger arrives in that same cycle (then REQ-018 applies, sop next cycle).
REQ-025 Trigger in same cycle as EOP transfer with pending full: pending to active, new frame written to pending; no overflow.
REQ-026 Trigger in SEND with pending full and no EOP transfer: frame dropped, pending unchanged, overflow high exactly next cycle.
REQ-027 out_data holds last value when out_valid low; out_sop/out_eop low when out_valid low.
REQ-028 No arithmetic on samples; data passes bit-exact, sign untouched.

Reset
REQ-029 reset_n low: immediately out_data=0, out_valid=0, out_sop=0, out_eop=0, out_channel=0, overflow=0, state IDLE, counter 0, pending empty, edge-detect history 0.
REQ-030 Reset mid-frame abandons active and pending frames; no partial beat after release.
REQ-031 First trigger after release follows REQ-018; with EDGE_TRIG=1, in_valid already high at release counts as a rising edge.

Structure
REQ-032 Shared package dechannelizer_pkg holds state enum (IDLE, SEND) and channel-index width function.
REQ-033 Pending buffer with full flag implemented as sub-module dechannelizer_frame_buf (write, read, full, data).

Verification
REQ-034 CHANNELS=2, WIDTH=24, out_ready=1, single trigger with ch0=0x123456, ch1=0xABCDEF -> beats 0x123456 (sop, ch 0) then 0xABCDEF (eop, ch 1) on cycles t+1, t+2; no overflow.
REQ-035 CHANNELS=4, out_ready toggled 1/0 each cycle -> 4 beats in order, each held stable during stall, sop on ch0 only, eop on ch3 only.
REQ-036 CHANNELS=4, out_ready=0, three triggers -> first active, second pending, third dropped with one overflow pulse; out_ready=1 then yields 8 contiguous beats, no bubble between frames.
REQ-037 EDGE_TRIG=1, in_valid held high 10 cycles -> exactly one frame; EDGE_TRIG=0 same stimulus, CHANNELS=2, out_ready=1 -> frames continuous, overflow pulses counted and reported.
REQ-038 reset_n asserted during beat 2 of 4 -> all outputs 0 same cycle; after release with no trigger, out_valid stays 0.
REQ-039 CHANNELS=1 -> each trigger produces one beat with sop=eop=1, out_channel=0.
